// File: rtl/vita49_ts_counter_pkg.sv
// -----------------------------------------------------------------------------
// vita49_ts_counter_pkg
// Shared definitions for the VITA-49 timestamp counter and the pack/unpack
// datapath: timestamp field widths and the timestamp-state encodings.
// No ports (package).
// -----------------------------------------------------------------------------
package vita49_ts_counter_pkg;

    localparam int TS_INT_W  = 32;
    localparam int TS_FRAC_W = 64;
    localparam int STATE_W   = 2;

    localparam logic [STATE_W-1:0] ST_UNSYNC   = 2'd0;
    localparam logic [STATE_W-1:0] ST_ARMED    = 2'd1;
    localparam logic [STATE_W-1:0] ST_LOCKED   = 2'd2;
    localparam logic [STATE_W-1:0] ST_HOLDOVER = 2'd3;

    // Time is trustworthy while locked to PPS or coasting in holdover.
    function automatic logic state_has_time(input logic [STATE_W-1:0] st);
        return (st == ST_LOCKED) || (st == ST_HOLDOVER);
    endfunction

endpackage

// File: rtl/vita49_ts_counter_if.sv
// -----------------------------------------------------------------------------
// vita49_ts_counter_if
// Timestamp bus from the counter to the packet header logic.
//   master : timestamp source (drives everything)
//   slave  : timestamp consumer
// Signals: ts_int, ts_frac, ts_valid, ts_state, pps_pulse, pps_missing,
//          pps_early, sps_count, sps_update.
// -----------------------------------------------------------------------------
interface vita49_ts_counter_if;
    import vita49_ts_counter_pkg::*;

    logic [TS_INT_W-1:0]  ts_int;
    logic [TS_FRAC_W-1:0] ts_frac;
    logic                 ts_valid;
    logic [STATE_W-1:0]   ts_state;
    logic                 pps_pulse;
    logic                 pps_missing;
    logic                 pps_early;
    logic [31:0]          sps_count;
    logic                 sps_update;

    modport master (
        output ts_int, ts_frac, ts_valid, ts_state, pps_pulse,
               pps_missing, pps_early, sps_count, sps_update
    );

    modport slave (
        input  ts_int, ts_frac, ts_valid, ts_state, pps_pulse,
               pps_missing, pps_early, sps_count, sps_update
    );
endinterface

// File: rtl/vita49_pps_sync.sv
// -----------------------------------------------------------------------------
// vita49_pps_sync
// Brings the asynchronous PPS level into the clock domain through a
// SYNC_STAGES-deep flop chain and emits a registered one-cycle pulse on its
// rising edge. pps_pulse is high SYNC_STAGES+1 edges after pps_in rises.
// Ports:
//   clk       in  clock
//   srst      in  synchronous active-high reset
//   pps_in    in  raw PPS level (asynchronous)
//   pps_pulse out one-cycle pulse on synchronized rising edge
// -----------------------------------------------------------------------------
module vita49_pps_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic pps_in,
    output logic pps_pulse
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic                   prev_reg;
    logic                   pulse_reg;

    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            assign sync_next[gi] = pps_in;
        end else begin : g_rest
            assign sync_next[gi] = sync_reg[gi-1];
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg  <= '0;
            prev_reg  <= 1'b0;
            pulse_reg <= 1'b0;
        end else begin
            sync_reg  <= sync_next;
            prev_reg  <= sync_reg[SYNC_STAGES-1];
            pulse_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
        end
    end

    assign pps_pulse = pulse_reg;

endmodule

// File: rtl/vita49_ts_counter.sv
// -----------------------------------------------------------------------------
// vita49_ts_counter
// VITA-49 timestamp source: integer seconds (TSI) plus sample-count
// fractional time (TSF), aligned to PPS with holdover when PPS goes missing.
// Optional feature macro: VITA49_TS_SPS_CAPTURE_EN (samples-per-second capture).
// Ports:
//   axis_clk      in   clock
//   axis_reset    in   synchronous active-high reset
//   pps_in        in   raw PPS level (asynchronous)
//   samp_en       in   one-cycle strobe per sample
//   set_sec       in   seconds value applied at the next PPS
//   set_sec_valid in   strobe latching set_sec
//   clear_status  in   clears sticky pps_missing / pps_early
//   ts            master modport of vita49_ts_counter_if (all outputs)
// -----------------------------------------------------------------------------
module vita49_ts_counter
    import vita49_ts_counter_pkg::*;
#(
    parameter int SAMP_RATE   = 100,
    parameter int PPS_TOL     = 16,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 32
) (
    input  logic                axis_clk,
    input  logic                axis_reset,
    input  logic                pps_in,
    input  logic                samp_en,
    input  logic [TS_INT_W-1:0] set_sec,
    input  logic                set_sec_valid,
    input  logic                clear_status,
    vita49_ts_counter_if.master ts
);

    localparam logic [CNT_W-1:0] ONE_V    = CNT_W'(1);
    localparam logic [CNT_W-1:0] EARLY_V  = CNT_W'(SAMP_RATE - PPS_TOL);
    localparam logic [CNT_W-1:0] MISS_V   = CNT_W'(SAMP_RATE + PPS_TOL);
    localparam logic [CNT_W-1:0] TOL_V    = CNT_W'(PPS_TOL);
    localparam logic [CNT_W-1:0] WRAP_V   = CNT_W'(SAMP_RATE - 1);
    localparam logic [CNT_W-1:0] HALF_V   = CNT_W'(SAMP_RATE / 2);

    logic                pps_pulse;
    logic [STATE_W-1:0]  state_reg, state_next;
    logic [TS_INT_W-1:0] tsi_reg, tsi_next;
    logic [CNT_W-1:0]    tsf_reg, tsf_next;
    logic [TS_INT_W-1:0] pend_sec_reg, pend_sec_next;
    logic                load_pend_reg, load_pend_next;
    logic                missing_reg, missing_next;
    logic                early_reg, early_next;
    logic                valid_reg;

    logic                load_now;
    logic [TS_INT_W-1:0] sec_src;
    logic [TS_INT_W-1:0] tsi_inc;
    logic [CNT_W-1:0]    tsf_inc;
    logic                early_ev;
    logic                miss_ev;

    vita49_pps_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pps_sync (
        .clk       (axis_clk),
        .srst      (axis_reset),
        .pps_in    (pps_in),
        .pps_pulse (pps_pulse)
    );

    // A set_sec_valid coincident with the PPS must win, so bypass the
    // pending register with the live input in that cycle.
    assign load_now = set_sec_valid | load_pend_reg;
    assign sec_src  = set_sec_valid ? set_sec : pend_sec_reg;
    assign tsi_inc  = tsi_reg + 32'd1;
    assign tsf_inc  = tsf_reg + ONE_V;

    always_comb begin
        state_next     = state_reg;
        tsi_next       = tsi_reg;
        tsf_next       = tsf_reg;
        pend_sec_next  = pend_sec_reg;
        load_pend_next = load_pend_reg;
        early_ev       = 1'b0;
        miss_ev        = 1'b0;

        if (set_sec_valid) begin
            pend_sec_next  = set_sec;
            load_pend_next = 1'b1;
        end

        case (state_reg)
            ST_UNSYNC: begin
                if (set_sec_valid) state_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (pps_pulse) begin
                    tsi_next       = sec_src;
                    tsf_next       = '0;
                    load_pend_next = 1'b0;
                    state_next     = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (pps_pulse) begin
                    tsi_next       = load_now ? sec_src : tsi_inc;
                    tsf_next       = '0;
                    load_pend_next = 1'b0;
                    early_ev       = (tsf_reg < EARLY_V);
                end else if (samp_en) begin
                    if (tsf_inc == MISS_V) begin
                        // PPS overdue: the second boundary already passed
                        // PPS_TOL samples ago, so restart TSF there.
                        tsi_next   = tsi_inc;
                        tsf_next   = TOL_V;
                        miss_ev    = 1'b1;
                        state_next = ST_HOLDOVER;
                    end else begin
                        tsf_next = tsf_inc;
                    end
                end
            end
            ST_HOLDOVER: begin
                if (pps_pulse) begin
                    // A PPS past mid-second closes the current second; an
                    // earlier one means holdover ran ahead, so keep TSI.
                    if (load_now)
                        tsi_next = sec_src;
                    else if (tsf_reg >= HALF_V)
                        tsi_next = tsi_inc;
                    tsf_next       = '0;
                    load_pend_next = 1'b0;
                    state_next     = ST_LOCKED;
                end else if (samp_en) begin
                    if (tsf_reg == WRAP_V) begin
                        tsf_next = '0;
                        tsi_next = tsi_inc;
                    end else begin
                        tsf_next = tsf_inc;
                    end
                end
            end
            default: state_next = ST_UNSYNC;
        endcase

        // Set events take precedence over a same-cycle clear.
        missing_next = miss_ev  | (missing_reg & ~clear_status);
        early_next   = early_ev | (early_reg   & ~clear_status);
    end

    always_ff @(posedge axis_clk) begin
        if (axis_reset) begin
            state_reg     <= ST_UNSYNC;
            tsi_reg       <= '0;
            tsf_reg       <= '0;
            pend_sec_reg  <= '0;
            load_pend_reg <= 1'b0;
            missing_reg   <= 1'b0;
            early_reg     <= 1'b0;
            valid_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            tsi_reg       <= tsi_next;
            tsf_reg       <= tsf_next;
            pend_sec_reg  <= pend_sec_next;
            load_pend_reg <= load_pend_next;
            missing_reg   <= missing_next;
            early_reg     <= early_next;
            valid_reg     <= state_has_time(state_next);
        end
    end

`ifdef VITA49_TS_SPS_CAPTURE_EN
    logic        capture;
    logic [31:0] sps_count_reg;
    logic        sps_update_reg;

    // Only a locked second is a meaningful measurement of the sample rate.
    assign capture = pps_pulse && (state_reg == ST_LOCKED);

    always_ff @(posedge axis_clk) begin
        if (axis_reset) begin
            sps_count_reg  <= '0;
            sps_update_reg <= 1'b0;
        end else begin
            sps_update_reg <= capture;
            if (capture)
                sps_count_reg <= 32'(tsf_reg) + 32'(samp_en);
        end
    end

    assign ts.sps_count  = sps_count_reg;
    assign ts.sps_update = sps_update_reg;
`else
    assign ts.sps_count  = '0;
    assign ts.sps_update = 1'b0;
`endif

    assign ts.ts_int      = tsi_reg;
    assign ts.ts_frac     = TS_FRAC_W'(tsf_reg);
    assign ts.ts_valid    = valid_reg;
    assign ts.ts_state    = state_reg;
    assign ts.pps_pulse   = pps_pulse;
    assign ts.pps_missing = missing_reg;
    assign ts.pps_early   = early_reg;

endmodule

// File: tb/tb_vita49_ts_counter.sv
// -----------------------------------------------------------------------------
// tb_vita49_ts_counter
// Directed scoreboard bench for vita49_ts_counter (SAMP_RATE=100, PPS_TOL=4,
// SYNC_STAGES=2). Stimulus pushes time-stamped expectations; a monitor on the
// falling edge pops and compares them, and checks pps_pulse timing.
// -----------------------------------------------------------------------------
module tb_vita49_ts_counter;
    import vita49_ts_counter_pkg::*;

`ifdef VITA49_TS_SPS_CAPTURE_EN
    localparam bit SPS_EN = 1'b1;
`else
    localparam bit SPS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pps_in;
    logic        samp_en;
    logic [31:0] set_sec;
    logic        set_sec_valid;
    logic        clear_status;

    vita49_ts_counter_if ts_bus ();

    vita49_ts_counter #(
        .SAMP_RATE   (100),
        .PPS_TOL     (4),
        .SYNC_STAGES (2),
        .CNT_W       (32)
    ) dut (
        .axis_clk      (clk),
        .axis_reset    (rst),
        .pps_in        (pps_in),
        .samp_en       (samp_en),
        .set_sec       (set_sec),
        .set_sec_valid (set_sec_valid),
        .clear_status  (clear_status),
        .ts            (ts_bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          t;
        string       name;
        logic [31:0] ti;
        logic [63:0] tf;
        logic [1:0]  st;
        logic        v;
        logic        miss;
        logic        early;
        logic [31:0] sps;
        logic        upd;
    } exp_t;

    exp_t exp_q[$];
    int   pulse_q[$];
    int   total = 0;
    int   bad   = 0;

    // Bench-side expected state, captured into each pushed expectation.
    logic [31:0] e_int;
    logic [1:0]  e_st;
    logic        e_miss;
    logic        e_early;
    logic [31:0] e_sps;
    int          rise_cyc;
    int          lref;

    task automatic chk_at(input int t, input string name, input logic [63:0] frac, input logic upd);
        exp_t e;
        e.t     = t;
        e.name  = name;
        e.ti    = e_int;
        e.tf    = frac;
        e.st    = e_st;
        e.v     = (e_st == 2'd2) || (e_st == 2'd3);
        e.miss  = e_miss;
        e.early = e_early;
        e.sps   = SPS_EN ? e_sps : 32'd0;
        e.upd   = SPS_EN ? upd : 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
        if (pps_in && cyc >= rise_cyc + 8) pps_in = 1'b0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    task automatic pps_rise();
        pps_in   = 1'b1;
        rise_cyc = cyc;
        pulse_q.push_back(cyc + 3);
    endtask

    // Monitor: compares whenever the DUT presents a pulse or a due expectation.
    always @(negedge clk) begin
        if (ts_bus.pps_pulse) begin
            total++;
            if (pulse_q.size() == 0) begin
                bad++;
                $display("FAIL pps_pulse: got pulse at cycle %0d, required none", cyc);
            end else begin
                int p;
                p = pulse_q.pop_front();
                if (p != cyc) begin
                    bad++;
                    $display("FAIL pps_pulse: got pulse at cycle %0d, required cycle %0d", cyc, p);
                end
            end
        end
        while (exp_q.size() > 0 && exp_q[0].t <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if ({ts_bus.ts_int, ts_bus.ts_frac, ts_bus.ts_state, ts_bus.ts_valid,
                 ts_bus.pps_missing, ts_bus.pps_early, ts_bus.sps_count, ts_bus.sps_update}
                !== {e.ti, e.tf, e.st, e.v, e.miss, e.early, e.sps, e.upd}) begin
                bad++;
                $display("FAIL %s @%0d: got int=%h frac=%0d st=%0d v=%0b miss=%0b early=%0b sps=%0d upd=%0b, required int=%h frac=%0d st=%0d v=%0b miss=%0b early=%0b sps=%0d upd=%0b",
                         e.name, cyc, ts_bus.ts_int, ts_bus.ts_frac, ts_bus.ts_state, ts_bus.ts_valid,
                         ts_bus.pps_missing, ts_bus.pps_early, ts_bus.sps_count, ts_bus.sps_update,
                         e.ti, e.tf, e.st, e.v, e.miss, e.early, e.sps, e.upd);
            end else begin
                $display("check %s @%0d: int=%h frac=%0d st=%0d ok", e.name, cyc, e.ti, e.tf, e.st);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pps_in = 1'b0; samp_en = 1'b0; set_sec = '0;
        set_sec_valid = 1'b0; clear_status = 1'b0;
        e_int = '0; e_st = 2'd0; e_miss = 1'b0; e_early = 1'b0; e_sps = '0;
        rise_cyc = -100;

        // 1: reset state, PPS with no set_sec has no effect
        repeat (3) step();
        rst = 1'b0;
        chk_at(cyc + 1, "reset", 64'd0, 1'b0);
        samp_en = 1'b1;
        step(); step();
        pps_rise();
        chk_at(cyc + 6, "unsync_pps", 64'd0, 1'b0);
        wait_until(cyc + 12);

        // 2: arm, lock on first PPS, one nominal second
        set_sec = 32'h1000; set_sec_valid = 1'b1;
        e_st = 2'd1;
        chk_at(cyc + 1, "armed", 64'd0, 1'b0);
        step();
        set_sec_valid = 1'b0;
        pps_rise();
        chk_at(cyc + 3, "armed_pulse", 64'd0, 1'b0);
        e_int = 32'h1000; e_st = 2'd2;
        lref = cyc + 4;
        chk_at(lref, "lock", 64'd0, 1'b0);
        wait_until(lref + 96);
        pps_rise();
        chk_at(lref + 99, "pre_pps", 64'd99, 1'b0);
        e_int = 32'h1001; e_sps = 32'd100;
        chk_at(lref + 100, "second", 64'd0, 1'b1);
        lref = lref + 100;

        // 3: missing PPS -> holdover, wrap, then relock on early PPS
        chk_at(lref + 103, "pre_miss", 64'd103, 1'b0);
        e_int = 32'h1002; e_st = 2'd3; e_miss = 1'b1;
        chk_at(lref + 104, "holdover", 64'd4, 1'b0);
        chk_at(lref + 199, "ho_99", 64'd99, 1'b0);
        e_int = 32'h1003;
        chk_at(lref + 200, "ho_wrap", 64'd0, 1'b0);
        wait_until(lref + 217);
        pps_rise();
        chk_at(lref + 220, "ho_pps", 64'd20, 1'b0);
        e_st = 2'd2;
        chk_at(lref + 221, "relock", 64'd0, 1'b0);
        lref = lref + 221;

        // 4: early PPS, then clear_status
        wait_until(lref + 47);
        pps_rise();
        e_int = 32'h1004; e_early = 1'b1; e_sps = 32'd51;
        chk_at(lref + 51, "early", 64'd0, 1'b1);
        lref = lref + 51;
        wait_until(lref + 4);
        clear_status = 1'b1;
        e_miss = 1'b0; e_early = 1'b0;
        chk_at(lref + 5, "clear", 64'd5, 1'b0);
        step();
        clear_status = 1'b0;

        // 5: set_sec while locked, then a set coincident with the pulse
        wait_until(lref + 10);
        set_sec = 32'h2000; set_sec_valid = 1'b1;
        step();
        set_sec_valid = 1'b0;
        wait_until(lref + 96);
        pps_rise();
        chk_at(lref + 99, "pre_load", 64'd99, 1'b0);
        e_int = 32'h2000; e_sps = 32'd100;
        chk_at(lref + 100, "load", 64'd0, 1'b1);
        lref = lref + 100;
        wait_until(lref + 96);
        pps_rise();
        e_int = 32'h2001;
        chk_at(lref + 100, "after_load", 64'd0, 1'b1);
        lref = lref + 100;
        wait_until(lref + 96);
        pps_rise();
        wait_until(lref + 99);
        set_sec = 32'h3000; set_sec_valid = 1'b1;
        e_int = 32'h3000;
        chk_at(lref + 100, "same_cycle_set", 64'd0, 1'b1);
        step();
        set_sec_valid = 1'b0;
        lref = lref + 100;
        wait_until(lref + 96);
        pps_rise();
        wait_until(lref + 99);
        samp_en = 1'b0;
        e_int = 32'h3001; e_sps = 32'd99;
        chk_at(lref + 100, "no_samp_pps", 64'd0, 1'b1);
        step();
        samp_en = 1'b1;
        lref = lref + 100;

        // 6: one-cycle reset mid-LOCKED, then PPS without arming
        wait_until(lref + 10);
        rst = 1'b1;
        e_int = '0; e_st = 2'd0; e_miss = 1'b0; e_early = 1'b0; e_sps = '0;
        chk_at(cyc + 1, "reset_mid", 64'd0, 1'b0);
        step();
        rst = 1'b0;
        chk_at(cyc + 2, "post_reset", 64'd0, 1'b0);
        wait_until(cyc + 3);
        pps_rise();
        chk_at(cyc + 6, "no_arm", 64'd0, 1'b0);
        wait_until(cyc + 15);

        total++;
        if (exp_q.size() != 0 || pulse_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d expectations and %0d pulses left, required 0 and 0",
                     exp_q.size(), pulse_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
